// File: rtl/rv_core_pkg.sv
// Shared core constants: datapath width, NOP encoding, major opcodes and fetch FSM states.
package rv_core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_ERROR = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: sequential PC+4 or branch target, with alignment check on the result.
module next_pc_sel #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  // Addition wraps naturally at XLEN bits.
  assign pc_plus4   = pc + XLEN'(4);
  assign next_pc    = pc_src ? pc_target : pc_plus4;
  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests words from instruction memory and presents
// the fetched instruction to decode; misaligned next-PC traps into a sticky error.
module instr_fetch_unit #(
  parameter int unsigned                 XLEN     = rv_core_pkg::XLEN,
  parameter logic [rv_core_pkg::XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic            advance,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  output logic            misalign_err
);

  import rv_core_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_d;
  logic [31:0]     instr_d;
  logic            valid_d;
  logic            err_d;
  logic            req_d;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc         (pc),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  assign imem_addr = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next register values.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    instr_d = instr;
    valid_d = instr_valid;
    err_d   = misalign_err;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (advance) begin
          valid_d = 1'b0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_ERROR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
        valid_d = 1'b0;
      end
    endcase
    req_d = (state_d == ST_FETCH);
  end

  // Output registers; request is registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      imem_req     <= 1'b1;
    end else begin
      pc           <= pc_d;
      instr        <= instr_d;
      instr_valid  <= valid_d;
      misalign_err <= err_d;
      imem_req     <= req_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with a behavioural reference model; two
// instances cover the zero reset PC and the wrapping reset PC 32'hFFFF_FFFC.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] RPC0    = 32'h0000_0000;
  localparam logic [31:0] RPC1    = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, pc_src, advance, imem_ack;
  logic [31:0] pc_target, imem_rdata;

  logic        req0, req1, valid0, valid1, err0, err1;
  logic [31:0] addr0, addr1, instr0, instr1, pc0, pc1, pcp0, pcp1;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0/1 = instance with RPC0/RPC1.
  logic [31:0] m_pc    [2];
  logic [31:0] m_instr [2];
  bit          m_valid [2];
  bit          m_err   [2];

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RPC0)) dut0 (
    .clk(clk), .rst(rst), .pc_src(pc_src), .pc_target(pc_target), .advance(advance),
    .imem_req(req0), .imem_addr(addr0), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr0), .pc(pc0), .pc_plus4(pcp0), .instr_valid(valid0), .misalign_err(err0)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RPC1)) dut1 (
    .clk(clk), .rst(rst), .pc_src(pc_src), .pc_target(pc_target), .advance(advance),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr1), .pc(pc1), .pc_plus4(pcp1), .instr_valid(valid1), .misalign_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the behavioural model for instance k.
  task automatic model_step(input int k, input logic [31:0] rpc);
    logic [31:0] nxt;
    if (rst) begin
      m_pc[k] = rpc; m_instr[k] = NOP; m_valid[k] = 0; m_err[k] = 0;
    end else if (m_err[k]) begin
      m_valid[k] = 0;
    end else if (!m_valid[k]) begin
      if (imem_ack) begin
        m_instr[k] = imem_rdata; m_valid[k] = 1;
      end
    end else if (advance) begin
      nxt = pc_src ? pc_target : m_pc[k] + 32'd4;
      m_valid[k] = 0;
      if (nxt % 4 != 0) m_err[k] = 1;
      else m_pc[k] = nxt;
    end
  endtask

  task automatic compare_all();
    check("pc0",     pc0,           m_pc[0]);
    check("instr0",  instr0,        m_instr[0]);
    check("valid0",  32'(valid0),   32'(m_valid[0]));
    check("err0",    32'(err0),     32'(m_err[0]));
    check("req0",    32'(req0),     32'(!m_valid[0] && !m_err[0]));
    check("addr0",   addr0,         m_pc[0]);
    check("pcp0",    pcp0,          m_pc[0] + 32'd4);
    check("pc1",     pc1,           m_pc[1]);
    check("instr1",  instr1,        m_instr[1]);
    check("valid1",  32'(valid1),   32'(m_valid[1]));
    check("err1",    32'(err1),     32'(m_err[1]));
    check("req1",    32'(req1),     32'(!m_valid[1] && !m_err[1]));
    check("addr1",   addr1,         m_pc[1]);
    check("pcp1",    pcp1,          m_pc[1] + 32'd4);
  endtask

  task automatic cyc(input logic r, input logic a, input logic [31:0] d,
                     input logic v, input logic s, input logic [31:0] t);
    rst = r; imem_ack = a; imem_rdata = d; advance = v; pc_src = s; pc_target = t;
    @(posedge clk);
    model_step(0, RPC0);
    model_step(1, RPC1);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; pc_src = 0; advance = 0; imem_ack = 0; pc_target = '0; imem_rdata = '0;

    // Reset for two cycles, then the first request.
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    check("rst_instr", instr0, NOP);
    check("rst_valid", 32'(valid0), 32'd0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    check("first_req", 32'(req0), 32'd1);
    check("first_addr", addr0, 32'h0);

    // Sequential fetch: zero-wait ack, then three wait cycles.
    cyc(0, 1, 32'h0050_0093, 0, 0, 32'h0);
    check("seq_instr0", instr0, 32'h0050_0093);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    check("seq_addr4", addr0, 32'h4);
    check("wrap_addr", addr1, 32'h0);
    check("wrap_err", 32'(err1), 32'd0);
    idle(3);
    cyc(0, 1, 32'h00A0_0113, 0, 0, 32'h0);
    check("seq_instr1", instr0, 32'h00A0_0113);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    check("seq_addr8", addr0, 32'h8);
    cyc(0, 1, 32'h0000_0033, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    cyc(0, 1, 32'h0000_0063, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    check("at_0x10", pc0, 32'h10);

    // Branch: pc_src without advance is ignored, then taken.
    cyc(0, 1, 32'h0400_0063, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 1, 32'h40);
    cyc(0, 0, 32'h0, 0, 1, 32'h40);
    check("br_hold", pc0, 32'h10);
    cyc(0, 0, 32'h0, 1, 1, 32'h40);
    check("br_addr", addr0, 32'h40);

    // Misaligned target traps and stays trapped until reset.
    cyc(0, 1, 32'h0000_0003, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 1, 1, 32'h42);
    check("mis_err", 32'(err0), 32'd1);
    check("mis_pc", pc0, 32'h40);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
      check("mis_req", 32'(req0), 32'd0);
      check("mis_valid", 32'(valid0), 32'd0);
      check("mis_sticky", 32'(err0), 32'd1);
    end
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    check("mis_clr", 32'(err0), 32'd0);

    // Reset in the same cycle as an ack discards the returned word.
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
    check("rmf_valid", 32'(valid0), 32'd0);
    check("rmf_instr", instr0, NOP);
    check("rmf_pc1", pc1, RPC1);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    check("rmf_req", 32'(req0), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 15) == 0) t[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) t = 32'hFFFF_FFFC;
      cyc($urandom_range(0, 63) == 0, 1'($urandom), $urandom, 1'($urandom),
          $urandom_range(0, 9) < 3, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
